cpu_clock_ctrl: RTL and testbench

Clock sequencer for the 8-bit CPU. It turns the 100 MHz board clock into single-cycle `cpu_tick` enables for the CPU datapath. Two modes are supported: free-running at `RUN_HZ`, and manual single-step from a debounced push button. It also produces a visible `cpu_clk` level for the LEDs and latches the CPU's HLT request. It sits between the board I/O (button, mode switch) and every CPU register's clock enable, so the whole CPU runs on `clk`.

---
 rtl/clk_ctrl_pkg.sv | 12 +
 rtl/btn_debounce.sv | 63 ++++++
 rtl/cpu_clock_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types for the CPU clock sequencer.
package clk_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        StRun    = 2'b00,
        StStep   = 2'b01,
        StHalted = 2'b10
    } clk_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stability debouncer and
// rising-edge pulse of the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d, level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the raw asynchronous button into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Count how long the synchronized level has differed from the accepted one.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debouncer state and the delayed level used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock sequencer: free-run divider, single-step from a debounced
// button, HLT latch and a visible cpu_clk level for the LEDs.
module cpu_clock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned RUN_HZ          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_btn,
    input  logic               step_mode,
    input  logic               halt,
    output logic               cpu_tick,
    output logic               cpu_clk,
    output logic [STATE_W-1:0] state,
    output logic               halted
);

    localparam int unsigned DIV   = CLK_HZ / RUN_HZ;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF);

    logic             mode_s1_q, mode_s2_q;
    logic [1:0]       settle_q;
    logic             mode_ok;
    logic             step_req;
    logic             unused_db_level;
    clk_state_t       state_q, state_d;
    logic             halt_evt, mode_chg;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (step_btn),
        .level(unused_db_level),
        .rise (step_req)
    );

    // Mode switch synchronizer; settle_q marks when the sync chain holds real samples,
    // so the FSM does not act on the reset value of the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            settle_q  <= 2'b00;
        end else begin
            mode_s1_q <= step_mode;
            mode_s2_q <= mode_s1_q;
            settle_q  <= {settle_q[0], 1'b1};
        end
    end

    assign mode_ok = settle_q[1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StStep;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: halt beats a mode change; HALTED is left only by reset.
    always_comb begin
        state_d  = state_q;
        halt_evt = 1'b0;
        mode_chg = 1'b0;
        unique case (state_q)
            StRun: begin
                if (halt) begin
                    state_d  = StHalted;
                    halt_evt = 1'b1;
                end else if (mode_ok && mode_s2_q) begin
                    state_d  = StStep;
                    mode_chg = 1'b1;
                end
            end
            StStep: begin
                if (halt) begin
                    state_d  = StHalted;
                    halt_evt = 1'b1;
                end else if (mode_ok && !mode_s2_q) begin
                    state_d  = StRun;
                    mode_chg = 1'b1;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StStep;
        endcase
    end

    // Outputs: tick generation, divider and cpu_clk high-time counter.
    always_comb begin
        tick_d = 1'b0;
        div_d  = '0;
        hi_d   = (hi_q != '0) ? hi_q - CNT_W'(1) : '0;
        unique case (state_q)
            StRun: begin
                // A tick due alongside a halt or mode change is dropped.
                if (!halt_evt && !mode_chg) begin
                    if (div_q == DIV_LAST) begin
                        tick_d = 1'b1;
                    end else begin
                        div_d = div_q + CNT_W'(1);
                    end
                end
            end
            StStep:  tick_d = step_req && !halt_evt && !mode_chg;
            default: tick_d = 1'b0;
        endcase
        if (tick_d) begin
            hi_d = HALF_LD;
        end
        if (halt_evt || (state_q == StHalted)) begin
            hi_d = '0;
        end
        clk_d = tick_d || (hi_d != '0);
    end

    // Registered datapath so cpu_tick and cpu_clk rise on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            hi_q   <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            hi_q   <= hi_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign cpu_tick = tick_q;
    assign cpu_clk  = clk_q;
    assign state    = state_q;
    assign halted   = (state_q == StHalted);

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with DIV=10, HALF=5, DEBOUNCE_CYCLES=4.
module tb_cpu_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst, step_btn, step_mode, halt;
    logic       cpu_tick, cpu_clk, halted;
    logic [1:0] state;

    int n_checks = 0;
    int n_fails  = 0;
    int ticks, first, clk_hi, acc;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(
        .CLK_HZ         (100),
        .RUN_HZ         (10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step_btn (step_btn),
        .step_mode(step_mode),
        .halt     (halt),
        .cpu_tick (cpu_tick),
        .cpu_clk  (cpu_clk),
        .state    (state),
        .halted   (halted)
    );

    // Advance one edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run n edges; i=1 is the first edge. Button is released after edge rel (0 = never).
    task automatic run(input int n, input int rel, output int n_tick, output int first_i,
                       output int n_hi);
        n_tick  = 0;
        first_i = -1;
        n_hi    = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (cpu_tick === 1'b1) begin
                n_tick++;
                if (first_i < 0) first_i = i;
            end
            if (cpu_clk === 1'b1) n_hi++;
            if (i == rel) step_btn = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        step_btn  = 1'b0;
        step_mode = 1'b0;
        halt      = 1'b0;
        tick();
        tick();
        check("rst_state", state, 2'b01);
        check("rst_tick", cpu_tick, 1'b0);
        check("rst_cpu_clk", cpu_clk, 1'b0);
        check("rst_halted", halted, 1'b0);

        // Free run: RUN on the third edge after release.
        rst = 1'b0;
        run(2, 0, ticks, first, clk_hi);
        check("settle_state", state, 2'b01);
        tick();
        check("run_state", state, 2'b00);
        run(9, 0, ticks, first, clk_hi);
        check("run_no_early_tick", ticks, 0);
        tick();
        check("run_first_tick", cpu_tick, 1'b1);
        check("run_first_cpu_clk", cpu_clk, 1'b1);
        run(9, 0, ticks, first, clk_hi);
        check("run_gap_ticks", ticks, 0);
        check("run_gap_clk_hi", clk_hi, 4);
        tick();
        check("run_second_tick", cpu_tick, 1'b1);
        run(4, 0, ticks, first, clk_hi);
        check("run_clk_hi_tail", clk_hi, 4);
        tick();
        check("run_clk_low", cpu_clk, 1'b0);

        // Halt on the cycle the next tick is due.
        run(4, 0, ticks, first, clk_hi);
        check("pre_halt_ticks", ticks, 0);
        halt = 1'b1;
        tick();
        check("halt_tick", cpu_tick, 1'b0);
        check("halt_state", state, 2'b10);
        check("halt_halted", halted, 1'b1);
        check("halt_cpu_clk", cpu_clk, 1'b0);
        halt      = 1'b0;
        step_btn  = 1'b1;
        step_mode = 1'b1;
        run(12, 0, ticks, first, clk_hi);
        acc       = ticks;
        step_btn  = 1'b0;
        step_mode = 1'b0;
        run(8, 0, ticks, first, clk_hi);
        check("halted_ticks", acc + ticks, 0);
        check("halted_clk_hi", clk_hi, 0);
        check("halted_sticky", state, 2'b10);
        step_mode = 1'b1;
        rst       = 1'b1;
        tick();
        check("halt_rst_state", state, 2'b01);
        check("halt_rst_halted", halted, 1'b0);
        rst = 1'b0;
        run(6, 0, ticks, first, clk_hi);
        check("step_idle_ticks", ticks, 0);
        check("step_idle_state", state, 2'b01);

        // Single step: held 10 edges, tick 7 edges after the first high sample.
        step_btn = 1'b1;
        run(20, 10, ticks, first, clk_hi);
        check("step_count", ticks, 1);
        check("step_latency", first, 8);
        check("step_clk_hi", clk_hi, 5);

        // Three short bounces.
        acc = 0;
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            run(3, 0, ticks, first, clk_hi);
            acc += ticks;
            step_btn = 1'b0;
            run(3, 0, ticks, first, clk_hi);
            acc += ticks;
        end
        run(10, 0, ticks, first, clk_hi);
        check("bounce_ticks", acc + ticks, 0);

        // Mode switch RUN -> STEP with div_cnt at 6.
        step_mode = 1'b0;
        run(2, 0, ticks, first, clk_hi);
        check("to_run_wait", state, 2'b01);
        tick();
        check("to_run_state", state, 2'b00);
        run(6, 0, ticks, first, clk_hi);
        check("run6_ticks", ticks, 0);
        step_mode = 1'b1;
        run(6, 0, ticks, first, clk_hi);
        check("to_step_ticks", ticks, 0);
        check("to_step_state", state, 2'b01);
        step_btn = 1'b1;
        run(20, 10, ticks, first, clk_hi);
        check("step2_count", ticks, 1);
        check("step2_latency", first, 8);

        // Back to RUN; a press while running must not add a tick.
        step_mode = 1'b0;
        run(2, 0, ticks, first, clk_hi);
        tick();
        check("rerun_state", state, 2'b00);
        step_btn = 1'b1;
        run(10, 10, ticks, first, clk_hi);
        check("rerun_count", ticks, 1);
        check("rerun_first", first, 10);
        step_mode = 1'b1;
        run(15, 0, ticks, first, clk_hi);
        check("restep_ticks", ticks, 0);
        check("restep_state", state, 2'b01);

        // Reset at debounce count 3 with the button held.
        step_btn = 1'b1;
        run(5, 0, ticks, first, clk_hi);
        check("pre_rst_ticks", ticks, 0);
        rst = 1'b1;
        tick();
        check("mid_rst_tick", cpu_tick, 1'b0);
        check("mid_rst_state", state, 2'b01);
        rst = 1'b0;
        run(9, 0, ticks, first, clk_hi);
        check("post_rst_count", ticks, 1);
        check("post_rst_latency", first, 8);
        check("post_rst_cpu_clk", cpu_clk, 1'b1);

        // Reset while cpu_clk is high.
        rst = 1'b1;
        tick();
        check("rst_cpu_clk_drop", cpu_clk, 1'b0);
        check("rst_cpu_clk_state", state, 2'b01);
        rst      = 1'b0;
        step_btn = 1'b0;
        run(3, 0, ticks, first, clk_hi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
